servo_status_tx: RTL and testbench
==================================

Name: servo_status_tx

Overview:
- UART transmitter that reports the servo controller's current state back to the host, on the return direction of the serial link.
- Snapshots the latched position code (1..16) and storage code (103..113), then sends a 4-byte status frame on TxD as 8N1.
- The host uses each frame to confirm that its command bytes were taken.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); must be >= 2.
- AUTO_SEND, 1, 1 = a change in {position,storage} triggers a frame; 0 = only send_req triggers a frame.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous reset, active-low.
- position  in  8  current latched position code.
- storage  in  8  current latched storage code.
- match  in  1  1 when the servo is in its commanded "match" pulse width.
- send_req  in  1  single-cycle request for a status frame.
- TxD  out  1  serial output; idle high.
- busy  out  1  high while a frame is in transmission.
- frame_done  out  1  one-cycle pulse after the last stop bit of a frame.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: TxD=1, busy=0, frame_done=0. Pending flag, bit counter, baud counter and byte index all 0. Change-detect register loads the current {position,storage} in the reset cycle, so reset alone does not trigger a frame.
- Trigger: raised on any of:
  - send_req=1, or
  - AUTO_SEND=1 and {position,storage} differs from the previous cycle's value.
- Pending flag: one deep. Triggers while busy set it; several triggers coalesce into one pending frame.
- Frame = 4 bytes, in order:
  - HEADER
  - P = snapshot of position
  - S = snapshot of storage with bit7 replaced by match
  - C = (HEADER + P + S) mod 256, where S is the modified byte
- Snapshot is taken in the cycle the frame starts, not in the trigger cycle. A pending frame therefore carries the newest values.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on the cycle after a trigger or pending flag is seen. busy rises in that same cycle and TxD=0.
  - START: holds TxD=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: drives 8 bits LSB first, each for CLKS_PER_BIT cycles, then -> STOP.
  - STOP: holds TxD=1 for CLKS_PER_BIT cycles. If the byte index is below 3, increment it and -> START with no idle gap. Otherwise -> IDLE.
- End of frame, on the STOP->IDLE transition cycle: busy=0 and frame_done=1 for one cycle.
- Back-to-back frames: if the pending flag is set at end of frame, the next frame starts one cycle after frame_done. The pending flag clears when that frame starts.
- Trigger in the same cycle as frame_done: counts as pending. It is not lost.
- Timing: frame length is exactly 40*CLKS_PER_BIT cycles of busy=1. Latency from trigger to TxD falling edge is 1 cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. Width is clog2(CLKS_PER_BIT).
- Reset mid-frame: on the next clk edge TxD returns to 1 and busy to 0. No partial byte is completed and the pending flag is cleared.
- Inputs position and storage are synchronous to clk; no synchronisers are needed.

Decomposition:
- Shared package servo_pkg holds:
  - HEADER default (8'hA5)
  - position code range 1..16 and storage code range 103..113
  - CLK_HZ = 50_000_000
  - state encoding enum for the FSM
- Sub-module uart_tx_byte: byte-level 8N1 shifter.
  - Ports: clk, rst_n, start, data[7:0], TxD, ready.
  - servo_status_tx keeps the frame sequencing, snapshot, checksum, trigger and pending logic.

Test Plan:
- CLKS_PER_BIT=4, position=3, storage=103, match=1, send_req pulse -> 4 bytes decoded as A5, 03, E7, 8F. busy high for 160 cycles. frame_done pulses once.
- After reset with AUTO_SEND=1 and inputs held constant -> TxD stays 1 and busy stays 0 for 1000 cycles.
- AUTO_SEND=1; position changes 3->4 mid-frame, then 4->5 mid-frame -> exactly one further frame, starting 1 cycle after frame_done, with P=05.
- send_req asserted in the same cycle as frame_done -> second frame starts on the next cycle with no lost request.
- rst_n low for 1 cycle during DATA of byte 2 -> TxD=1 and busy=0 on the next edge. No frame_done. A new send_req produces a full correct frame.
- Checksum wrap: position=16, storage=113, match=1 -> S=F1, C=(A5+10+F1) mod 256 = A6.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, FSM encoding and checksum helper
// for the servo status transmitter.
package servo_pkg;

    localparam logic [7:0] HEADER_DEF = 8'hA5;

    localparam logic [7:0] POS_MIN = 8'd1;
    localparam logic [7:0] POS_MAX = 8'd16;
    localparam logic [7:0] STO_MIN = 8'd103;
    localparam logic [7:0] STO_MAX = 8'd113;

    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    function automatic logic [7:0] frame_sum(
        input logic [7:0] h,
        input logic [7:0] p,
        input logic [7:0] s
    );
        return h + p + s;
    endfunction

endpackage

// File: rtl/servo_status_tx_if.sv
// Status/serial bundle between the servo core
// and the status transmitter.
interface servo_status_tx_if;

    logic [7:0] position;
    logic [7:0] storage;
    logic       match;
    logic       send_req;
    logic       TxD;
    logic       busy;
    logic       frame_done;

    modport master (
        output position, storage, match, send_req,
        input  TxD, busy, frame_done
    );

    modport slave (
        input  position, storage, match, send_req,
        output TxD, busy, frame_done
    );

endinterface

// File: rtl/servo_status_tx_uart.sv
// Byte-level 8N1 shifter; accepts the next byte in the
// last stop-bit cycle so bytes go out without idle gaps.
module uart_tx_byte
    import servo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TxD,
    output logic       ready
);

    localparam int unsigned BW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = START;
            START: if (baud_end) state_d = DATA;
            DATA:  if (baud_end && bit_q == 3'd7) state_d = STOP;
            STOP:  if (baud_end) state_d = start ? START : IDLE;
        endcase
    end

    always_comb begin
        TxD   = 1'b1;
        ready = 1'b0;
        unique case (state_q)
            IDLE:  ready = 1'b1;
            START: TxD = 1'b0;
            DATA:  TxD = shift_q[0];
            STOP:  ready = baud_end;
        endcase
    end

    always_comb begin
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (state_q == IDLE) baud_d = '0;
        if (ready && start) shift_d = data;
        if (state_q == START && baud_end) bit_d = '0;
        if (state_q == DATA && baud_end) begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/servo_status_tx.sv
// Frame sequencer: trigger/pending logic, snapshot and
// checksum for the 4-byte status frame.
module servo_status_tx
    import servo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter bit          AUTO_SEND    = 1'b1,
    parameter logic [7:0]  HEADER       = HEADER_DEF
) (
    input logic              clk,
    input logic              rst_n,
    servo_status_tx_if.slave bus
);

    logic [15:0] prev_q;
    logic        active_q, active_d;
    logic        pend_q, pend_d;
    logic        done_q, done_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  pos_q, pos_d;
    logic [7:0]  sto_q, sto_d;
    logic        trig, launch, byte_end, start;
    logic [7:0]  next_byte;
    logic        ready, txd;

    assign trig = bus.send_req |
        (AUTO_SEND & ({bus.position, bus.storage} != prev_q));
    assign launch   = !active_q && (trig || pend_q);
    assign byte_end = active_q && ready;
    assign start    = launch || (byte_end && idx_q != 2'd3);

    // idx_q is the byte on the wire; queue the one after it
    always_comb begin
        next_byte = HEADER;
        if (!launch) begin
            unique case (idx_q)
                2'd0:    next_byte = pos_q;
                2'd1:    next_byte = sto_q;
                default: next_byte = frame_sum(HEADER, pos_q, sto_q);
            endcase
        end
    end

    always_comb begin
        active_d = active_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        idx_d    = idx_q;
        pos_d    = pos_q;
        sto_d    = sto_q;
        if (launch) begin
            active_d = 1'b1;
            pend_d   = 1'b0;
            idx_d    = 2'd0;
            pos_d    = bus.position;
            sto_d    = {bus.match, bus.storage[6:0]};
        end else begin
            if (trig) pend_d = 1'b1;
            if (byte_end) begin
                if (idx_q == 2'd3) begin
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    idx_d    = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        prev_q <= {bus.position, bus.storage};
        if (!rst_n) begin
            active_q <= 1'b0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            pos_q    <= '0;
            sto_q    <= '0;
        end else begin
            active_q <= active_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            pos_q    <= pos_d;
            sto_q    <= sto_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .data  (next_byte),
        .TxD   (txd),
        .ready (ready)
    );

    assign bus.TxD        = txd;
    assign bus.busy       = active_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_servo_status_tx.sv
// Directed bench for servo_status_tx: records TxD/busy/frame_done
// per cycle and decodes frames at mid-bit.
module tb_servo_status_tx;

    localparam int CPB = 4;
    localparam int BYTE_LEN = 10 * CPB;
    localparam int FL = 4 * BYTE_LEN;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    logic txa [DEPTH];
    logic bsa [DEPTH];
    logic fda [DEPTH];

    servo_status_tx_if bus();

    servo_status_tx #(
        .CLKS_PER_BIT (CPB),
        .AUTO_SEND    (1'b1),
        .HEADER       (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] want
    );
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        if (n < DEPTH) begin
            txa[n] = bus.TxD;
            bsa[n] = bus.busy;
            fda[n] = bus.frame_done;
            n++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_req();
        bus.send_req = 1'b1;
        step();
        bus.send_req = 1'b0;
    endtask

    function automatic int find_start(input int from);
        for (int i = (from < 1) ? 1 : from; i < n; i++)
            if (bsa[i] === 1'b1 && bsa[i-1] !== 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_starts(input int from);
        int c = 0;
        for (int i = (from < 1) ? 1 : from; i < n; i++)
            if (bsa[i] === 1'b1 && bsa[i-1] !== 1'b1) c++;
        return c;
    endfunction

    function automatic int count_done(input int from);
        int c = 0;
        for (int i = from; i < n; i++)
            if (fda[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic check_frame(
        input string      tag,
        input int         from,
        input int         s_want,
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        logic [7:0] want [4];
        logic [7:0] got;
        int s, ferr, blen, b;
        want = '{b0, b1, b2, b3};
        s = find_start(from);
        check({tag, "_start"}, s, s_want);
        if (s >= 1 && s + FL < n) begin
            ferr = 0;
            for (int k = 0; k < 4; k++) begin
                b = s + k * BYTE_LEN;
                if (txa[b + CPB/2] !== 1'b0) ferr++;
                if (txa[b + 9*CPB + CPB/2] !== 1'b1) ferr++;
                for (int j = 0; j < 8; j++)
                    got[j] = txa[b + (j+1)*CPB + CPB/2];
                check($sformatf("%s_byte%0d", tag, k), got, want[k]);
            end
            check({tag, "_framing"}, ferr, 0);
            blen = 0;
            for (int i = s; i < n && bsa[i] === 1'b1; i++) blen++;
            check({tag, "_busy_len"}, blen, FL);
            check({tag, "_done"}, fda[s + FL], 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst_n        = 1'b0;
        bus.send_req = 1'b0;
        bus.position = 8'd3;
        bus.storage  = 8'd103;
        bus.match    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", bus.TxD, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.frame_done, 1'b0);
        rst_n = 1'b1;

        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.TxD !== 1'b1 || bus.busy !== 1'b0) cnt++;
        end
        check("idle_quiet", cnt, 0);

        // single requested frame
        n = 0;
        pulse_req();
        repeat (FL + 10) step();
        check_frame("t1", 1, 1, 8'hA5, 8'h03, 8'hE7, 8'h8F);
        check("t1_done_cnt", count_done(0), 1);

        // two auto changes mid-frame coalesce into one frame
        n = 0;
        pulse_req();
        repeat (50) step();
        bus.position = 8'd4;
        repeat (50) step();
        bus.position = 8'd5;
        repeat (2 * FL + 20) step();
        check_frame("t3a", 1, 1, 8'hA5, 8'h03, 8'hE7, 8'h8F);
        check_frame("t3b", 2, FL + 2, 8'hA5, 8'h05, 8'hE7, 8'h91);
        check("t3_frames", count_starts(1), 2);
        check("t3_done_cnt", count_done(0), 2);

        // request in the frame_done cycle
        n = 0;
        pulse_req();
        repeat (FL) step();
        pulse_req();
        repeat (FL + 10) step();
        check("t4_done_cycle", fda[FL + 1], 1'b1);
        check_frame("t4a", 1, 1, 8'hA5, 8'h05, 8'hE7, 8'h91);
        check_frame("t4b", 2, FL + 2, 8'hA5, 8'h05, 8'hE7, 8'h91);
        check("t4_frames", count_starts(1), 2);

        // reset in DATA of byte 2 (bit3 = 0), with a pending request
        n = 0;
        pulse_req();
        repeat (49) step();
        pulse_req();
        repeat (47) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (300) step();
        check("t5_pre_busy", bsa[98], 1'b1);
        check("t5_pre_txd", txa[98], 1'b0);
        check("t5_rst_txd", txa[99], 1'b1);
        check("t5_rst_busy", bsa[99], 1'b0);
        check("t5_no_done", count_done(0), 0);
        check("t5_no_restart", count_starts(99), 0);
        n = 0;
        pulse_req();
        repeat (FL + 10) step();
        check_frame("t5new", 1, 1, 8'hA5, 8'h05, 8'hE7, 8'h91);

        // auto trigger on both codes, checksum wraps
        n = 0;
        bus.position = 8'd16;
        bus.storage  = 8'd113;
        step();
        repeat (FL + 10) step();
        check_frame("t6", 1, 1, 8'hA5, 8'h10, 8'hF1, 8'hA6);

        // match alone is not a trigger, but is carried in S
        n = 0;
        bus.match = 1'b0;
        repeat (20) step();
        check("t7_match_quiet", count_starts(1), 0);
        n = 0;
        pulse_req();
        repeat (FL + 10) step();
        check_frame("t7", 1, 1, 8'hA5, 8'h10, 8'h71, 8'h26);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
